// File: rtl/wb_stage.sv
// wb_stage: writeback stage with load formatting, misaligned-load trap,
// late-result arbitration with anti-starvation, and retired-instruction counter.
module wb_stage #(
    parameter int XLEN          = 32,
    parameter int LATE_MAX_WAIT = 4,
    parameter int INSTRET_W     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_rd_addr,
    input  logic [1:0]           mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_load_word,
    input  logic [XLEN-1:0]      mem_pc_plus4,
    input  logic                 late_valid,
    output logic                 late_ready,
    input  logic [4:0]           late_rd_addr,
    input  logic [XLEN-1:0]      late_data,
    output logic                 we,
    output logic [4:0]           rd_addr,
    output logic [XLEN-1:0]      rd_data_in,
    output logic                 load_misaligned,
    output logic [INSTRET_W-1:0] instret
);
    localparam logic [3:0] MAX_WAIT = 4'(LATE_MAX_WAIT);
    logic [3:0]           wait_q, wait_d;
    logic                 we_q, we_d, mis_q, mis_d;
    logic [4:0]           rd_q, rd_d;
    logic [XLEN-1:0]      data_q, data_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 starve, mem_fire, late_fire, misaligned;
    logic [1:0]           off;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic [XLEN-1:0]      load_v, mem_res;

    assign starve     = late_valid && (wait_q >= MAX_WAIT);
    assign mem_ready  = !starve;
    assign late_ready = late_valid && (!mem_valid || starve);
    assign mem_fire   = mem_valid && mem_ready;
    assign late_fire  = late_valid && late_ready;

    assign off        = mem_alu_result[1:0];
    assign byte_v     = mem_load_word[{off, 3'b000} +: 8];
    assign half_v     = mem_load_word[{off[1], 4'b0000} +: 16];
    assign misaligned = (mem_wb_sel == 2'b01) &&
                        (((mem_funct3[1:0] == 2'b01) && off[0]) || ((mem_funct3 == 3'b010) && (off != 2'b00)));

    // funct3[2] selects zero-extension; unknown load types fall back to the full word
    assign load_v = (mem_funct3 == 3'b000) ? {{(XLEN-8){byte_v[7]}}, byte_v} :
                    (mem_funct3 == 3'b100) ? {{(XLEN-8){1'b0}}, byte_v} :
                    (mem_funct3 == 3'b001) ? {{(XLEN-16){half_v[15]}}, half_v} :
                    (mem_funct3 == 3'b101) ? {{(XLEN-16){1'b0}}, half_v} : mem_load_word;
    assign mem_res = (mem_wb_sel == 2'b01) ? load_v :
                     (mem_wb_sel == 2'b10) ? mem_pc_plus4 : mem_alu_result;

    always_comb begin
        we_d      = 1'b0;
        mis_d     = 1'b0;
        rd_d      = rd_q;
        data_d    = data_q;
        instret_d = instret_q + INSTRET_W'(mem_fire && !misaligned);
        wait_d    = (!late_valid || late_fire) ? 4'd0 : ((wait_q == 4'hF) ? wait_q : wait_q + 4'd1);
        if (mem_fire) begin
            we_d   = mem_reg_write && (mem_rd_addr != 5'd0) && !misaligned;
            mis_d  = misaligned;
            rd_d   = mem_rd_addr;
            data_d = mem_res;
        end else if (late_fire) begin
            we_d   = late_rd_addr != 5'd0;
            rd_d   = late_rd_addr;
            data_d = late_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q    <= '0;
            we_q      <= 1'b0;
            mis_q     <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            instret_q <= '0;
        end else begin
            wait_q    <= wait_d;
            we_q      <= we_d;
            mis_q     <= mis_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            instret_q <= instret_d;
        end
    end

    assign we              = we_q;
    assign rd_addr         = rd_q;
    assign rd_data_in      = data_q;
    assign load_misaligned = mis_q;
    assign instret         = instret_q;
endmodule
